// File: rtl/lc4_isa_pkg.sv
// LC4 ISA definitions shared by the decode stage: opcode encodings, link register
// and the packed bundle of per-instruction decode flags.
package lc4_isa_pkg;

   localparam int OPC_W    = 5;
   localparam int LINK_REG = 7;

   localparam logic [OPC_W-1:0] OP_BR_LAST = 5'b00100;
   localparam logic [OPC_W-1:0] OP_ADD     = 5'b00101;
   localparam logic [OPC_W-1:0] OP_SUB     = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ADDI    = 5'b00111;
   localparam logic [OPC_W-1:0] OP_JSR     = 5'b01000;
   localparam logic [OPC_W-1:0] OP_ANDI    = 5'b01001;
   localparam logic [OPC_W-1:0] OP_RTI     = 5'b01010;
   localparam logic [OPC_W-1:0] OP_CONST   = 5'b01011;
   localparam logic [OPC_W-1:0] OP_SLL     = 5'b01100;
   localparam logic [OPC_W-1:0] OP_SRL     = 5'b01101;
   localparam logic [OPC_W-1:0] OP_SDRH    = 5'b01110;
   localparam logic [OPC_W-1:0] OP_SDRL    = 5'b01111;
   localparam logic [OPC_W-1:0] OP_CHKL    = 5'b10000;
   localparam logic [OPC_W-1:0] OP_SDL     = 5'b10010;
   localparam logic [OPC_W-1:0] OP_CHKH    = 5'b10011;
   localparam logic [OPC_W-1:0] OP_TCS     = 5'b10100;
   localparam logic [OPC_W-1:0] OP_TCDH    = 5'b10101;

   typedef struct packed {
      logic r1re;
      logic r2re;
      logic regfile_we;
      logic nzp_we;
      logic select_pc_plus_one;
      logic is_branch;
      logic is_control_insn;
   } decode_flags_t;

endpackage

// File: rtl/lc4_decode_comb.sv
// Pure combinational LC4 decoder: instruction word to register selects and decode flags.
module lc4_decode_comb #(
   parameter int INSN_W = 20,
   parameter int OPC_W  = 5,
   parameter int REG_W  = 5
) (
   input  logic [INSN_W-1:0]          insn,
   output lc4_isa_pkg::decode_flags_t flags,
   output logic [REG_W-1:0]           r1sel,
   output logic [REG_W-1:0]           r2sel,
   output logic [REG_W-1:0]           wsel
);
   import lc4_isa_pkg::*;

   logic [OPC_W-1:0] opc;
   assign opc = insn[INSN_W-1 -: OPC_W];

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
      flags = '0;
      r1sel = insn[2*REG_W-1 -: REG_W];
      r2sel = insn[REG_W-1:0];
      wsel  = insn[3*REG_W-1 -: REG_W];
      case (opc)
         OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SDRH, OP_SDRL, OP_SDL, OP_TCS, OP_TCDH: begin
            flags.r1re = 1'b1;
            flags.r2re = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_CHKL, OP_CHKH: flags.r1re = 1'b1;
         OP_JSR: begin
            wsel                     = REG_W'(LINK_REG);
            flags.select_pc_plus_one = 1'b1;
            flags.is_control_insn    = 1'b1;
         end
         OP_RTI: begin
            r1sel                 = REG_W'(LINK_REG);
            flags.is_control_insn = 1'b1;
         end
         default: ;
      endcase
      flags.is_branch  = (opc <= OP_BR_LAST);
      flags.nzp_we     = flags.r1re | (opc == OP_CONST) | (opc == OP_JSR);
      // CHKL/CHKH set condition codes only; they never write the register file.
      flags.regfile_we = flags.nzp_we & (opc != OP_CHKL) & (opc != OP_CHKH);
   end

endmodule

// File: rtl/lc4_decode_stage.sv
// Registered LC4 decode stage with valid/ready handshake, flush, and a per-register
// pending-write scoreboard that stalls RAW/WAW-overflow hazards.
module lc4_decode_stage #(
   parameter int INSN_W   = 20,
   parameter int OPC_W    = 5,
   parameter int REG_W    = 5,
   parameter int SB_CNT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [INSN_W-1:0] in_insn,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INSN_W-1:0] out_insn,
   output logic [REG_W-1:0]  out_r1sel,
   output logic [REG_W-1:0]  out_r2sel,
   output logic [REG_W-1:0]  out_wsel,
   output logic              out_r1re,
   output logic              out_r2re,
   output logic              out_regfile_we,
   output logic              out_nzp_we,
   output logic              out_select_pc_plus_one,
   output logic              out_is_branch,
   output logic              out_is_control_insn,
   input  logic              wb_valid,
   input  logic [REG_W-1:0]  wb_sel,
   input  logic              flush,
   output logic              stall_hazard
);
   import lc4_isa_pkg::*;

   localparam int NUM_REGS = 2**REG_W;
   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

   decode_flags_t      dec_flags;
   logic [REG_W-1:0]   dec_r1sel, dec_r2sel, dec_wsel;
   decode_flags_t      out_flags;

   logic [SB_CNT_W-1:0] pend      [NUM_REGS];
   logic [SB_CNT_W-1:0] pend_next [NUM_REGS];
   logic [SB_CNT_W:0]   cnt_up    [NUM_REGS];
   logic [SB_CNT_W:0]   cnt_down  [NUM_REGS];
   logic [NUM_REGS-1:0] sb_underflow;

   logic hazard, accept, flush_dec;

   lc4_decode_comb #(
      .INSN_W (INSN_W),
      .OPC_W  (OPC_W),
      .REG_W  (REG_W)
   ) u_decode (
      .insn  (in_insn),
      .flags (dec_flags),
      .r1sel (dec_r1sel),
      .r2sel (dec_r2sel),
      .wsel  (dec_wsel)
   );

   // No bypass: a writeback only becomes visible through pend on the following cycle.
   assign hazard = in_valid & ((dec_flags.r1re       & (pend[dec_r1sel] != '0))
                             | (dec_flags.r2re       & (pend[dec_r2sel] != '0))
                             | (dec_flags.regfile_we & (pend[dec_wsel]  == CNT_MAX)));

   assign stall_hazard = hazard;
   assign in_ready     = (~out_valid | out_ready) & ~hazard & ~flush & ~rst;
   assign accept       = in_valid & in_ready;
   assign flush_dec    = flush & out_valid & out_flags.regfile_we;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_up[i]       = {1'b0, pend[i]}
                         + (SB_CNT_W+1)'(accept & dec_flags.regfile_we & (dec_wsel == REG_W'(i)));
         cnt_down[i]     = (SB_CNT_W+1)'(wb_valid & (wb_sel == REG_W'(i)))
                         + (SB_CNT_W+1)'(flush_dec & (out_wsel == REG_W'(i)));
         sb_underflow[i] = cnt_up[i] < cnt_down[i];
         pend_next[i]    = sb_underflow[i] ? '0 : SB_CNT_W'(cnt_up[i] - cnt_down[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_insn  <= '0;
         out_r1sel <= '0;
         out_r2sel <= '0;
         out_wsel  <= '0;
         out_flags <= '0;
         // NOTE: the scoreboard array is control state, so it is reset explicitly like any flop.
         for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         pend <= pend_next;
         if (accept) begin
            out_valid <= 1'b1;
            out_insn  <= in_insn;
            out_r1sel <= dec_r1sel;
            out_r2sel <= dec_r2sel;
            out_wsel  <= dec_wsel;
            out_flags <= dec_flags;
         end else if (out_ready | flush) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Retiring a writer that was never counted is a downstream protocol error.
   always_ff @(posedge clk) begin
      if (!rst) assert (sb_underflow == '0);
   end

   assign out_r1re               = out_flags.r1re;
   assign out_r2re               = out_flags.r2re;
   assign out_regfile_we         = out_flags.regfile_we;
   assign out_nzp_we             = out_flags.nzp_we;
   assign out_select_pc_plus_one = out_flags.select_pc_plus_one;
   assign out_is_branch          = out_flags.is_branch;
   assign out_is_control_insn    = out_flags.is_control_insn;

endmodule

// File: tb/tb_lc4_decode_stage.sv
// Self-checking bench for lc4_decode_stage: directed scenarios plus random traffic,
// all compared each cycle against a behavioural model of the stage.
module tb_lc4_decode_stage;

   localparam int PMAX = 3;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [19:0] in_insn, out_insn;
   logic [4:0]  out_r1sel, out_r2sel, out_wsel, wb_sel;
   logic        out_r1re, out_r2re, out_regfile_we, out_nzp_we;
   logic        out_select_pc_plus_one, out_is_branch, out_is_control_insn;
   logic        wb_valid, flush, stall_hazard;

   int checks = 0;
   int errors = 0;

   lc4_decode_stage #(.INSN_W(20), .OPC_W(5), .REG_W(5), .SB_CNT_W(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_insn(in_insn), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
      .out_r1sel(out_r1sel), .out_r2sel(out_r2sel), .out_wsel(out_wsel),
      .out_r1re(out_r1re), .out_r2re(out_r2re), .out_regfile_we(out_regfile_we),
      .out_nzp_we(out_nzp_we), .out_select_pc_plus_one(out_select_pc_plus_one),
      .out_is_branch(out_is_branch), .out_is_control_insn(out_is_control_insn),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush), .stall_hazard(stall_hazard)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit r1re, r2re, we, nzp, pc1, br, ctl;
      int r1, r2, w;
   } dec_t;

   int          pend_m [32];
   bit          ov_m;
   logic [19:0] oi_m;
   dec_t        od_m;

   function automatic logic [19:0] mk(input int op, input int rd, input int rs, input int rt);
      logic [4:0] o, d, s, t;
      o = 5'(op); d = 5'(rd); s = 5'(rs); t = 5'(rt);
      return {o, d, s, t};
   endfunction

   // Decode rules restated from the ISA tables as opcode sets.
   function automatic dec_t dec_model(input logic [19:0] insn);
      dec_t d;
      int   op;
      op    = int'(insn[19:15]);
      d.r1re = op inside {5, 6, 7, 9, 12, 13, 14, 15, 16, 18, 19, 20, 21};
      d.r2re = op inside {5, 6, 12, 13, 14, 15, 18, 20, 21};
      d.pc1  = (op == 8);
      d.ctl  = (op == 8) || (op == 10);
      d.br   = (op <= 4);
      d.nzp  = d.r1re || (op == 11) || (op == 8);
      d.we   = d.nzp && (op != 16) && (op != 19);
      d.r1   = (op == 10) ? 7 : int'(insn[9:5]);
      d.r2   = int'(insn[4:0]);
      d.w    = (op == 8) ? 7 : int'(insn[14:10]);
      return d;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [19:0] insn, input bit ordy,
                        input bit wb, input int wsel, input bit fl, input bit r);
      in_valid = v; in_insn = insn; out_ready = ordy;
      wb_valid = wb; wb_sel = 5'(wsel); flush = fl; rst = r;
   endtask

   // One clock: predict comb outputs, advance the model, compare registered state.
   task automatic cycle();
      dec_t d;
      bit   hz, rdy, acc;
      d   = dec_model(in_insn);
      hz  = in_valid && ((d.r1re && pend_m[d.r1] != 0) || (d.r2re && pend_m[d.r2] != 0)
                         || (d.we && pend_m[d.w] == PMAX));
      rdy = (!ov_m || out_ready) && !hz && !flush && !rst;
      acc = in_valid && rdy;
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(rdy));
      check("stall_hazard", 32'(stall_hazard), 32'(hz));
      if (rst) begin
         for (int i = 0; i < 32; i++) pend_m[i] = 0;
         ov_m = 0; oi_m = '0;
         od_m = '{default: 0};
      end else begin
         if (flush && ov_m && od_m.we) pend_m[od_m.w]--;
         if (wb_valid) pend_m[int'(wb_sel)]--;
         if (acc && d.we) pend_m[d.w]++;
         for (int i = 0; i < 32; i++) if (pend_m[i] < 0) pend_m[i] = 0;
         if (acc) begin
            ov_m = 1; oi_m = in_insn; od_m = d;
         end else if (out_ready || flush) begin
            ov_m = 0;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(ov_m));
      check("out_insn", 32'(out_insn), 32'(oi_m));
      check("out_r1sel", 32'(out_r1sel), 32'(od_m.r1));
      check("out_r2sel", 32'(out_r2sel), 32'(od_m.r2));
      check("out_wsel", 32'(out_wsel), 32'(od_m.w));
      check("out_flags", {25'd0, out_r1re, out_r2re, out_regfile_we, out_nzp_we,
                          out_select_pc_plus_one, out_is_branch, out_is_control_insn},
            {25'd0, od_m.r1re, od_m.r2re, od_m.we, od_m.nzp, od_m.pc1, od_m.br, od_m.ctl});
      for (int i = 0; i < 32; i++)
         check($sformatf("pend%0d", i), 32'(dut.pend[i]), 32'(pend_m[i]));
   endtask

   task automatic do_reset();
      drive(0, '0, 0, 0, 0, 0, 1);
      cycle();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
      ov_m = 0; oi_m = '0; od_m = '{default: 0};
      do_reset();
      do_reset();

      // RAW stall on r3 until its writer retires; accepted the cycle after wb.
      drive(1, mk(5, 3, 1, 2), 1, 0, 0, 0, 0); cycle();
      drive(1, mk(5, 4, 3, 0), 1, 0, 0, 0, 0); cycle(); cycle();
      drive(1, mk(5, 4, 3, 0), 1, 1, 3, 0, 0); cycle();
      drive(1, mk(5, 4, 3, 0), 1, 0, 0, 0, 0); cycle();
      drive(0, '0, 1, 0, 0, 0, 0); cycle();

      // Back-pressure holds the bundle and freezes the scoreboard.
      do_reset();
      drive(1, mk(7, 1, 0, 0), 1, 0, 0, 0, 0); cycle();
      drive(1, mk(9, 2, 0, 0), 0, 0, 0, 0, 0); cycle(); cycle(); cycle();
      drive(1, mk(9, 2, 0, 0), 1, 0, 0, 0, 0); cycle();

      // CHKL writes NZP only; JSR targets the link register.
      do_reset();
      drive(1, mk(16, 9, 1, 0), 1, 0, 0, 0, 0); cycle();
      drive(1, mk(8, 0, 0, 0), 1, 0, 0, 0, 0); cycle();
      drive(1, mk(10, 0, 0, 0), 1, 0, 0, 0, 0); cycle();
      drive(1, mk(11, 4, 0, 0), 1, 0, 0, 0, 0); cycle();
      drive(1, mk(2, 0, 0, 0), 1, 0, 0, 0, 0); cycle();

      // Saturating write count on r5: the fourth writer waits for a retire.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1, mk(7, 5, 0, 0), 1, 0, 0, 0, 0); cycle();
      end
      drive(1, mk(7, 5, 0, 0), 1, 0, 0, 0, 0); cycle(); cycle();
      drive(1, mk(7, 5, 0, 0), 1, 1, 5, 0, 0); cycle();
      drive(1, mk(7, 5, 0, 0), 1, 0, 0, 0, 0); cycle();

      // Flush of a held r6 writer, alone and combined with a retire to r6.
      do_reset();
      drive(1, mk(7, 6, 0, 0), 0, 0, 0, 0, 0); cycle();
      drive(0, '0, 0, 0, 0, 1, 0); cycle();
      drive(1, mk(7, 6, 0, 0), 1, 0, 0, 0, 0); cycle(); cycle();
      drive(0, '0, 0, 1, 6, 1, 0); cycle();
      drive(0, '0, 1, 0, 0, 0, 0); cycle();

      // Reset in the middle of a stall drops everything.
      do_reset();
      drive(1, mk(7, 2, 0, 0), 0, 0, 0, 0, 0); cycle();
      drive(1, mk(5, 3, 2, 0), 0, 0, 0, 0, 1); cycle();
      drive(0, '0, 0, 0, 0, 0, 0); cycle();

      // Random traffic on a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         int  r, held;
         bit  wb;
         r    = int'($urandom_range(0, 7));
         flush = ($urandom_range(0, 15) == 0);
         held = (flush && ov_m && od_m.we && od_m.w == r) ? 1 : 0;
         wb   = (pend_m[r] - held >= 1) && ($urandom_range(0, 1) == 1);
         drive($urandom_range(0, 3) != 0,
               mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7))),
               $urandom_range(0, 3) != 0, wb, r, flush, $urandom_range(0, 63) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
